fifo_read_arbiter: RTL
======================

# fifo_read_arbiter

Read-side arbiter for the asynchronous FIFO, clocked in the read domain. It shares the single FIFO read port among NUM_REQ consumers using round-robin arbitration with bounded bursts. It drives the pointer block's r_en from the granted requester, watches the FIFO empty flag, and returns each popped word tagged with its owner's ID.

## Interface
- NUM_REQ, 4: number of consumers, 2..8.
- DATA_WIDTH, 8: FIFO word width.
- BURST_LEN, 4: maximum pops per grant, 1..15.
- CNT_WIDTH, 16: width of each statistics counter (used only with the stats macro).
- r_clk  in  1  read-domain clock.
- rrst_n  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  per-consumer read request, level-sensitive.
- empty  in  1  registered empty flag from the read pointer block.
- r_data  in  DATA_WIDTH  FIFO memory read data at the current read address, valid in the same cycle as r_en.
- r_en  out  1  pop strobe to the read pointer block.
- gnt  out  NUM_REQ  one-hot current owner, registered.
- busy  out  1  high while in BURST.
- rd_valid  out  1  one-cycle strobe: rd_data and rd_id hold a popped word.
- rd_data  out  DATA_WIDTH  popped word, registered.
- rd_id  out  clog2(NUM_REQ)  index of the consumer that owns rd_data.
- stat_cnt  out  NUM_REQ*CNT_WIDTH  per-consumer pop counts, packed with consumer 0 in the LSBs. Present only with the stats macro.

## Operation
- The FSM has two states: IDLE and BURST.
- IDLE:
  - Grant when req is nonzero and empty is low.
  - The winner is the first requester at or after rr_ptr, searching cyclically.
  - On a grant: register gnt as one-hot, set owner, clear beat, go to BURST.
  - When there is no request or empty is high: stay in IDLE with gnt = 0.
- BURST:
  - r_en = req[owner] & ~empty, combinational from registered state and the registered empty flag.
  - Each pop (r_en = 1) increments beat.
  - Exit to IDLE on any of these:
    - the pop where beat = BURST_LEN-1;
    - req[owner] low;
    - empty high.
  - On exit: rr_ptr = owner+1, modulo NUM_REQ, and gnt clears.
- Data return:
  - On a pop, register r_data into rd_data and owner into rd_id.
  - rd_valid pulses on the next cycle.
  - rd_data holds its value between pops.
- r_en is never high while empty is high.
- r_en is never high in IDLE.
- At most one gnt bit is set at any time.
- A requester that drops req mid-burst forfeits the rest of its burst. Words already popped are still delivered.
- beat is 4 bits wide and never exceeds BURST_LEN-1.

## Timing
- Reset values: gnt=0, r_en=0, busy=0, rd_valid=0, rd_data=0, rd_id=0, rr_ptr=0, beat=0, state IDLE, stat_cnt=0.
- req sampled in IDLE in cycle N → gnt/busy high in N+1 → first r_en in N+1 → rd_valid in N+2.
- Back-to-back bursts have exactly one IDLE cycle between them, so a full burst occupies BURST_LEN+1 cycles.
- A full burst with data available: BURST_LEN consecutive pops.
- Empty rising mid-burst: no pop that cycle, FSM returns to IDLE next cycle.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Asserting rrst_n low mid-burst clears all outputs immediately. No rd_valid is produced for a pop in flight.

## Configuration
- FIFO_RD_ARB_STATS_EN
  - Defined: instantiates NUM_REQ counters of CNT_WIDTH bits. Counter i increments on each pop where owner = i. Counters saturate at all-ones and drive stat_cnt.
  - Undefined: no counters and no stat_cnt port. Arbitration behaviour is identical in both builds.

## Structure
- Shared package fifo_arb_pkg holds:
  - the FSM state typedef (ST_IDLE, ST_BURST);
  - the beat counter width constant (4);
  - a function for the round-robin next-index calculation.
- One sub-module, rr_pick: combinational cyclic priority picker. Inputs: req and rr_ptr. Outputs: one-hot winner and its index.

## Test plan
- NUM_REQ=4, BURST_LEN=4, req=0001, FIFO holds 10 words → pops of 4, 4, 2. Each group of 4 is separated by one IDLE cycle. rd_id=0 throughout. Ends in IDLE with empty=1.
- req=1111 held, FIFO kept non-empty → grant order 0,1,2,3,0. Each grant lasts 4 pops.
- Owner 2 drops req after 2 pops → exactly 2 rd_valid with rd_id=2. Next grant goes to 3.
- empty forced high while in BURST with req held → r_en stays 0 that cycle and FSM returns to IDLE. No new grant until empty=0.
- rrst_n pulsed low on the 2nd beat of a burst → all outputs are 0 in the same cycle. After release, first grant goes to the lowest requesting index starting from 0.
- With FIFO_RD_ARB_STATS_EN defined and CNT_WIDTH=4: 20 pops by consumer 1 → stat_cnt[7:4]=4'hF, saturated. Other counters stay 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO read-side arbiter
//
// Purpose : FSM state encoding, beat counter width and the round-robin
//           successor function used by fifo_read_arbiter and rr_pick.
// Ports   : none (package).

package fifo_arb_pkg;

  // Arbiter FSM: IDLE picks a winner, BURST pops on its behalf.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Beat counter width; holds up to BURST_LEN-1 for BURST_LEN <= 15.
  localparam int unsigned BEAT_W = 4;

  // Cyclic successor of idx in the range 0..n-1.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_read_arbiter_rr_pick.sv
// rtl/fifo_read_arbiter_rr_pick.sv - combinational cyclic priority picker
//
// Purpose : Finds the first asserted request at or after rr_ptr, wrapping
//           from NUM_REQ-1 back to 0.
// Ports   : req       in  NUM_REQ  request vector
//           rr_ptr    in  ID_W     index with highest priority
//           win_oh    out NUM_REQ  one-hot winner (zero when no request)
//           win_idx   out ID_W     index of the winner (zero when none)
//           win_valid out 1        at least one request is asserted

module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [ID_W-1:0]    win_idx,
  output logic               win_valid
);

  logic [ID_W-1:0] scan_idx;

  // Walk NUM_REQ positions starting at rr_ptr; the first hit wins and
  // later hits are ignored through win_valid.
  always_comb begin
    win_oh    = '0;
    win_idx   = '0;
    win_valid = 1'b0;
    scan_idx  = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_valid && req[scan_idx]) begin
        win_valid        = 1'b1;
        win_idx          = scan_idx;
        win_oh[scan_idx] = 1'b1;
      end
      scan_idx = ID_W'(rr_next(32'(scan_idx), 32'(NUM_REQ)));
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// rtl/fifo_read_arbiter.sv - round-robin burst arbiter for the async FIFO read port
//
// Purpose : Shares one FIFO read port among NUM_REQ consumers. A winner is
//           picked in IDLE, then owns the port for up to BURST_LEN pops.
//           Every popped word is returned registered and tagged with its
//           owner's index.
// Macro   : FIFO_RD_ARB_STATS_EN adds saturating per-consumer pop counters
//           (CNT_WIDTH bits each) on stat_cnt.
// Ports   : r_clk     in  1                  read-domain clock
//           rrst_n    in  1                  async active-low reset
//           req       in  NUM_REQ            per-consumer read request
//           empty     in  1                  registered FIFO empty flag
//           r_data    in  DATA_WIDTH         FIFO data at the read address
//           r_en      out 1                  pop strobe
//           gnt       out NUM_REQ            one-hot owner, registered
//           busy      out 1                  burst in progress
//           rd_valid  out 1                  rd_data/rd_id hold a popped word
//           rd_data   out DATA_WIDTH         popped word
//           rd_id     out clog2(NUM_REQ)     owner of rd_data
//           stat_cnt  out NUM_REQ*CNT_WIDTH  pop counts, consumer 0 in LSBs
//                                            (stats build only)

module fifo_read_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
`ifdef FIFO_RD_ARB_STATS_EN
  ,
  parameter int CNT_WIDTH  = 16
`endif
) (
  input  logic                       r_clk,
  input  logic                       rrst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       empty,
  input  logic [DATA_WIDTH-1:0]      r_data,
  output logic                       r_en,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       busy,
  output logic                       rd_valid,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic [$clog2(NUM_REQ)-1:0] rd_id
`ifdef FIFO_RD_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_WIDTH-1:0] stat_cnt
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;

  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [ID_W-1:0]       rd_id_q;

  logic [NUM_REQ-1:0] win_oh;
  logic [ID_W-1:0]    win_idx;
  logic               win_valid;

  logic pop;
  logic owner_req;
  logic last_beat;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .win_oh    (win_oh),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  assign owner_req = req[owner_q];
  assign last_beat = (beat_q == BEAT_W'(BURST_LEN - 1));

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    gnt_d    = gnt_q;
    pop      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (win_valid && !empty) begin
          gnt_d   = win_oh;
          owner_d = win_idx;
          beat_d  = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        // Only registered state and the registered empty flag feed r_en,
        // so the pop strobe has no path through the picker.
        pop = owner_req & ~empty;
        if (pop) begin
          beat_d = beat_q + BEAT_W'(1);
        end
        // Burst ends on its last pop, on request withdrawal, or when the
        // FIFO runs dry; the next search starts just past the owner.
        if ((pop && last_beat) || !owner_req || empty) begin
          state_d  = ST_IDLE;
          gnt_d    = '0;
          beat_d   = '0;
          rr_ptr_d = ID_W'(rr_next(32'(owner_q), 32'(NUM_REQ)));
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
      gnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
      gnt_q    <= gnt_d;
    end
  end

  // Read data is captured on the pop edge, so rd_valid trails r_en by
  // one cycle and rd_data holds until the next pop.
  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_id_q    <= '0;
    end else begin
      rd_valid_q <= pop;
      if (pop) begin
        rd_data_q <= r_data;
        rd_id_q   <= owner_q;
      end
    end
  end

  assign r_en     = pop;
  assign gnt      = gnt_q;
  assign busy     = (state_q == ST_BURST);
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_id    = rd_id_q;

`ifdef FIFO_RD_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [CNT_WIDTH-1:0] cnt_q;

    // Saturating: an all-ones counter stops rather than wrapping to zero.
    always_ff @(posedge r_clk or negedge rrst_n) begin
      if (!rrst_n) begin
        cnt_q <= '0;
      end else if (pop && (owner_q == ID_W'(i)) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end

    assign stat_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end
`endif

endmodule
